// File: rtl/eth_tx_arb_if.sv
// Bus between the TX protocol handlers, the TX arbiter and the eth MAC TX FIFO write port.
// The master modport is the arbiter; the slave modport is the handler/FIFO side.
interface eth_tx_arb_if #(
    parameter int unsigned NREQ = 2
);
    localparam int unsigned DATA_W = 8 * NREQ;

    logic [NREQ-1:0]   i_req;
    logic [DATA_W-1:0] i_data;
    logic [NREQ-1:0]   i_valid;
    logic [NREQ-1:0]   i_last;
    logic [NREQ-1:0]   o_grant;
    logic [NREQ-1:0]   o_ready;
    logic              i_wready;
    logic [7:0]        o_wdata;
    logic              o_wvalid;
    logic              o_wlast;
    logic              o_busy;
    logic              o_abort;

    modport master (
        input  i_req, i_data, i_valid, i_last, i_wready,
        output o_grant, o_ready, o_wdata, o_wvalid, o_wlast, o_busy, o_abort
    );

    modport slave (
        output i_req, i_data, i_valid, i_last, i_wready,
        input  o_grant, o_ready, o_wdata, o_wvalid, o_wlast, o_busy, o_abort
    );
endinterface

// File: rtl/eth_tx_arb.sv
// Frame-granular round-robin arbiter for the byte-wide eth TX write port, with a fixed inter-frame gap.
// Optional frame-length watchdog enabled by defining ETH_TX_ARB_WDOG_EN.
module eth_tx_arb #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned GAP_CYC = 2,
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned LEN_W   = 11
) (
    input  logic          i_clk,
    input  logic          i_rst,
    eth_tx_arb_if.master  bus
);
    localparam int unsigned PTR_W = $clog2(NREQ);
    localparam int unsigned GAP_W = 4;

    if (NREQ < 2 || NREQ > 4 || GAP_CYC < 1 || GAP_CYC > 15 || (MAX_LEN >> LEN_W) != 0) begin : g_bad_params
        $error("eth_tx_arb: illegal parameter set");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_GAP} state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             wvalid_q, wvalid_d;
    logic             wlast_q, wlast_d;
    logic             busy_q, busy_d;
    logic             abort_q, abort_d;

    logic [NREQ-1:0]  ready;
    logic             beat;
    logic [7:0]       sel_data;
    logic             sel_last;
    logic             pick_found;
    logic [PTR_W-1:0] pick_idx;
    int unsigned      pick_dist;
    int unsigned      pick_best;
    logic             wdog_hit;

    assign ready = grant_q & {NREQ{(state_q == ST_XFER) && bus.i_wready}};
    assign beat  = |(ready & bus.i_valid);

    // Round-robin pick: the requester closest upward from the pointer wins.
    always_comb begin
        pick_idx  = '0;
        pick_dist = 0;
        pick_best = NREQ;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pick_dist = (k + NREQ - 32'(ptr_q)) % NREQ;
            if (bus.i_req[k] && pick_dist < pick_best) begin
                pick_best = pick_dist;
                pick_idx  = PTR_W'(k);
            end
        end
        pick_found = (pick_best != NREQ);
    end

    // Owner's byte lane; grant is one-hot so at most one lane matches.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant_q[k]) begin
                sel_data = bus.i_data[8*k +: 8];
                sel_last = bus.i_last[k];
            end
        end
    end

`ifdef ETH_TX_ARB_WDOG_EN
    logic [LEN_W-1:0] len_q, len_d;

    assign wdog_hit = (len_q + LEN_W'(1)) == LEN_W'(MAX_LEN);

    always_comb begin
        len_d = len_q;
        if (state_q == ST_IDLE) begin
            len_d = '0;
        end else if (beat) begin
            len_d = len_q + LEN_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            len_q <= '0;
        end else begin
            len_q <= len_d;
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        gap_d    = gap_q;
        wdata_d  = wdata_q;
        wvalid_d = 1'b0;
        wlast_d  = 1'b0;
        abort_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    ptr_d             = PTR_W'((32'(pick_idx) + 32'd1) % NREQ);
                    state_d           = ST_XFER;
                end
            end
            ST_XFER: begin
                if (beat) begin
                    wdata_d  = sel_data;
                    wvalid_d = 1'b1;
                    wlast_d  = sel_last | wdog_hit;
                    abort_d  = wdog_hit & ~sel_last;
                    if (sel_last | wdog_hit) begin
                        grant_d = '0;
                        gap_d   = GAP_W'(GAP_CYC);
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                gap_d = gap_q - GAP_W'(1);
                if (gap_q == GAP_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Synchronous reset drops any frame in flight without emitting a last byte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            gap_q    <= '0;
            wdata_q  <= '0;
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            gap_q    <= gap_d;
            wdata_q  <= wdata_d;
            wvalid_q <= wvalid_d;
            wlast_q  <= wlast_d;
            busy_q   <= busy_d;
            abort_q  <= abort_d;
        end
    end

    assign bus.o_ready  = ready;
    assign bus.o_grant  = grant_q;
    assign bus.o_wdata  = wdata_q;
    assign bus.o_wvalid = wvalid_q;
    assign bus.o_wlast  = wlast_q;
    assign bus.o_busy   = busy_q;
    assign bus.o_abort  = abort_q;
endmodule

// File: tb/tb_eth_tx_arb.sv
// Self-checking bench for eth_tx_arb: directed frames, stall, reset, optional watchdog,
// and random multi-frame traffic against a frame-level round-robin reference.
module tb_eth_tx_arb;
    localparam int unsigned NREQ    = 2;
    localparam int unsigned GAP_CYC = 2;
`ifdef ETH_TX_ARB_WDOG_EN
    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned LEN_W   = 3;
`else
    localparam int unsigned MAX_LEN = 1518;
    localparam int unsigned LEN_W   = 11;
`endif
    localparam int unsigned RLEN_MAX = (MAX_LEN < 6) ? MAX_LEN : 6;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    int         nfr  [NREQ];
    int         flen [NREQ][4];
    logic [7:0] fb   [NREQ][4][8];

    eth_tx_arb_if #(.NREQ(NREQ)) bus ();

    eth_tx_arb #(
        .NREQ(NREQ), .GAP_CYC(GAP_CYC), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int k, input logic [7:0] d, input logic v, input logic l);
        bus.i_data[8*k +: 8] = d;
        bus.i_valid[k]       = v;
        bus.i_last[k]        = l;
    endtask

    task automatic clr_inputs();
        bus.i_req    = '0;
        bus.i_data   = '0;
        bus.i_valid  = '0;
        bus.i_last   = '0;
        bus.i_wready = 1'b1;
    endtask

    task automatic do_reset();
        clr_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Replays the frames in nfr/flen/fb, all requested up front, and checks the output stream.
    task automatic run_frames(input string tag, input int budget);
        int         rem [NREQ];
        int         cf  [NREQ];
        int         cb  [NREQ];
        int         own [$];
        logic [7:0] ed  [$];
        logic       el  [$];
        int ptr = 0;
        int w;
        int oi = 0;
        int fdone = 0;
        int gcnt = 0;
        bit gcount = 1'b0;
        int cyc = 0;
        int extra = 0;
        for (int k = 0; k < NREQ; k++) begin
            rem[k] = nfr[k];
            cf[k]  = 0;
            cb[k]  = 0;
        end
        // Reference: frame-level round robin over requesters that still have frames.
        while (1) begin
            w = -1;
            for (int i = 0; i < NREQ; i++) begin
                if (w < 0 && rem[(ptr + i) % NREQ] > 0) w = (ptr + i) % NREQ;
            end
            if (w < 0) break;
            own.push_back(w);
            for (int b = 0; b < flen[w][nfr[w] - rem[w]]; b++) begin
                ed.push_back(fb[w][nfr[w] - rem[w]][b]);
                el.push_back(1'(b == flen[w][nfr[w] - rem[w]] - 1));
            end
            rem[w]--;
            ptr = (w + 1) % NREQ;
        end

        while (oi < ed.size() && cyc < budget) begin
            bus.i_wready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NREQ; k++) begin
                bus.i_req[k] = (cf[k] < nfr[k]);
                if (bus.o_grant[k] && cf[k] < nfr[k]) begin
                    drv(k, fb[k][cf[k]][cb[k]], 1'($urandom_range(0, 3) != 0),
                        1'(cb[k] == flen[k][cf[k]] - 1));
                end else begin
                    drv(k, 8'($urandom), 1'($urandom), 1'($urandom));
                end
            end
            #1;
            for (int k = 0; k < NREQ; k++) begin
                if (bus.o_ready[k] && bus.i_valid[k]) begin
                    if (bus.i_last[k]) begin
                        cf[k]++;
                        cb[k] = 0;
                    end else begin
                        cb[k]++;
                    end
                end
            end
            tick();
            cyc++;
            if (bus.o_wvalid) begin
                chk({tag, "_wdata"}, 32'(bus.o_wdata), 32'(ed[oi]));
                chk({tag, "_wlast"}, 32'(bus.o_wlast), 32'(el[oi]));
                chk({tag, "_abort"}, 32'(bus.o_abort), 32'd0);
                oi++;
                if (bus.o_wlast) begin
                    fdone++;
                    gcount = 1'b1;
                    gcnt   = 0;
                end
            end
            if (bus.o_grant != '0) begin
                if (fdone < own.size()) begin
                    chk({tag, "_grant"}, 32'(bus.o_grant), 32'd1 << own[fdone]);
                end else begin
                    chk({tag, "_grant_spurious"}, 32'(bus.o_grant), 32'd0);
                end
                if (gcount) begin
                    chk({tag, "_gap"}, 32'(gcnt), 32'(GAP_CYC + 1));
                    gcount = 1'b0;
                end
            end else if (gcount) begin
                gcnt++;
            end
        end
        clr_inputs();
        chk({tag, "_done"}, 32'(oi), 32'(ed.size()));
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.o_wvalid) extra++;
        end
        chk({tag, "_extra"}, 32'(extra), 32'd0);
        chk({tag, "_idle_busy"}, 32'(bus.o_busy), 32'd0);
    endtask

    initial begin
        clr_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_grant", 32'(bus.o_grant), 32'd0);
        chk("rst_wdata", 32'(bus.o_wdata), 32'd0);
        chk("rst_wvalid", 32'(bus.o_wvalid), 32'd0);
        chk("rst_wlast", 32'(bus.o_wlast), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_abort", 32'(bus.o_abort), 32'd0);
        rst = 1'b0;

        // Single 3-byte frame from requester 0.
        bus.i_req = 2'b01;
        drv(0, 8'hA1, 1'b1, 1'b0);
        tick();
        chk("t1_grant", 32'(bus.o_grant), 32'h1);
        chk("t1_wvalid0", 32'(bus.o_wvalid), 32'd0);
        tick();
        chk("t1_a1", {22'd0, bus.o_wvalid, bus.o_wlast, bus.o_wdata}, {22'd0, 2'b10, 8'hA1});
        drv(0, 8'hA2, 1'b1, 1'b0);
        tick();
        chk("t1_a2", {22'd0, bus.o_wvalid, bus.o_wlast, bus.o_wdata}, {22'd0, 2'b10, 8'hA2});
        drv(0, 8'hA3, 1'b1, 1'b1);
        bus.i_req = 2'b00;
        tick();
        chk("t1_a3", {22'd0, bus.o_wvalid, bus.o_wlast, bus.o_wdata}, {22'd0, 2'b11, 8'hA3});
        chk("t1_grant_off", 32'(bus.o_grant), 32'd0);
        chk("t1_busy_gap", 32'(bus.o_busy), 32'd1);
        drv(0, 8'h00, 1'b0, 1'b0);
        tick();
        chk("t1_gap2", {30'd0, bus.o_busy, bus.o_wvalid}, 32'h2);
        tick();
        chk("t1_busy_fall", 32'(bus.o_busy), 32'd0);

        // Requester 1 with a 3-cycle wready stall after byte 2.
        bus.i_req = 2'b10;
        drv(1, 8'hB1, 1'b1, 1'b0);
        tick();
        chk("t3_grant", 32'(bus.o_grant), 32'h2);
        tick();
        chk("t3_b1", {23'd0, bus.o_wvalid, bus.o_wdata}, {23'd0, 1'b1, 8'hB1});
        drv(1, 8'hB2, 1'b1, 1'b0);
        tick();
        chk("t3_b2", {23'd0, bus.o_wvalid, bus.o_wdata}, {23'd0, 1'b1, 8'hB2});
        drv(1, 8'hB3, 1'b1, 1'b0);
        bus.i_wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_stall_ready", 32'(bus.o_ready), 32'd0);
            tick();
            chk("t3_stall_wvalid", 32'(bus.o_wvalid), 32'd0);
            chk("t3_stall_grant", 32'(bus.o_grant), 32'h2);
        end
        bus.i_wready = 1'b1;
        tick();
        chk("t3_b3", {22'd0, bus.o_wvalid, bus.o_wlast, bus.o_wdata}, {22'd0, 2'b10, 8'hB3});
        drv(1, 8'hB4, 1'b1, 1'b1);
        bus.i_req = 2'b00;
        tick();
        chk("t3_b4", {22'd0, bus.o_wvalid, bus.o_wlast, bus.o_wdata}, {22'd0, 2'b11, 8'hB4});
        drv(1, 8'h00, 1'b0, 1'b0);
        tick();
        tick();

        // Reset mid-frame; afterwards the pointer is back at 0 so requester 0 wins a tie.
        bus.i_req = 2'b01;
        drv(0, 8'hC1, 1'b1, 1'b0);
        tick();
        tick();
        drv(0, 8'hC2, 1'b1, 1'b0);
        tick();
        chk("t5_c2", 32'(bus.o_wdata), 32'hC2);
        rst = 1'b1;
        bus.i_req = 2'b00;
        drv(0, 8'hC3, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        chk("t5_rst_out", {29'd0, bus.o_wvalid, bus.o_wlast, bus.o_busy}, 32'd0);
        chk("t5_rst_grant", 32'(bus.o_grant), 32'd0);
        drv(0, 8'h00, 1'b0, 1'b0);
        tick();
        chk("t5_no_wlast", {30'd0, bus.o_wvalid, bus.o_wlast}, 32'd0);
        bus.i_req = 2'b11;
        tick();
        chk("t5_regrant", 32'(bus.o_grant), 32'h1);
        drv(0, 8'hD1, 1'b1, 1'b1);
        bus.i_req = 2'b00;
        tick();
        chk("t5_d1", {22'd0, bus.o_wvalid, bus.o_wlast, bus.o_wdata}, {22'd0, 2'b11, 8'hD1});
        drv(0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();

`ifdef ETH_TX_ARB_WDOG_EN
        // Six bytes with no last: the watchdog truncates at MAX_LEN.
        do_reset();
        bus.i_req = 2'b01;
        drv(0, 8'hE0, 1'b1, 1'b0);
        tick();
        chk("wd_grant", 32'(bus.o_grant), 32'h1);
        for (int b = 0; b < 4; b++) begin
            drv(0, 8'(8'hE1 + b), 1'b1, 1'b0);
            tick();
            chk("wd_byte", {21'd0, bus.o_wvalid, bus.o_wlast, bus.o_abort, bus.o_wdata},
                {21'd0, 1'b1, 1'(b == 3), 1'(b == 3), 8'(8'hE1 + b)});
        end
        chk("wd_release", 32'(bus.o_grant), 32'd0);
        bus.i_req = 2'b00;
        for (int b = 4; b < 6; b++) begin
            drv(0, 8'(8'hE1 + b), 1'b1, 1'b0);
            tick();
            chk("wd_drop", {30'd0, bus.o_wvalid, bus.o_abort}, 32'd0);
        end
        clr_inputs();
        tick();
        tick();
`endif

        // One 2-byte frame each from reset, then two frames each.
        for (int run = 1; run <= 2; run++) begin
            do_reset();
            for (int k = 0; k < NREQ; k++) begin
                nfr[k] = run;
                for (int f = 0; f < 4; f++) begin
                    flen[k][f] = 2;
                    for (int b = 0; b < 8; b++) fb[k][f][b] = 8'(16 * k + 4 * f + b);
                end
            end
            run_frames((run == 1) ? "t2" : "t4", 500);
        end

        // Random frame sets, lengths, valids and wready stalls.
        for (int run = 0; run < 4; run++) begin
            do_reset();
            for (int k = 0; k < NREQ; k++) begin
                nfr[k] = int'($urandom_range(1, 4));
                for (int f = 0; f < 4; f++) begin
                    flen[k][f] = int'($urandom_range(1, RLEN_MAX));
                    for (int b = 0; b < 8; b++) fb[k][f][b] = 8'($urandom);
                end
            end
            run_frames("rnd", 2000);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
